// File: rtl/instr_decode_stage_pkg.sv
// rtl/instr_decode_stage_pkg.sv - decode-stage types, field positions and the instruction decoder
// Shared by the FIFO-buffered decode stage and anything that needs to read its bundles.
package PkgInstrDecodeStage;

   localparam int GROUP_LSB = 28;
   localparam int RA_LSB    = 24;
   localparam int RB_LSB    = 20;
   localparam int RC_LSB    = 16;
   localparam int OPC_LSB   = 0;
   localparam int IMM_LSB   = 0;

   localparam logic [3:0] BNE_TWOREGS_ONESIMM = 4'h9;
   localparam logic [3:0] CALLEQ_THREEREGS    = 4'h1;
   localparam logic [3:0] STB_THREEREGSLDST   = 4'h3;

   typedef struct packed {
      logic [3:0]  group;
      logic [3:0]  ra_index;
      logic [3:0]  rb_index;
      logic [3:0]  rc_index;
      logic [3:0]  opcode;
      logic [15:0] imm_val;
      logic        causes_stall;
      logic        illegal;
   } PortOut_InstrDecodeStage;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_WAIT_CLEAR = 2'd1,
      ST_HALT       = 2'd2
   } state_t;

   function automatic PortOut_InstrDecodeStage decode_instr(input logic [31:0] instr);
      PortOut_InstrDecodeStage d;
      d          = '0;
      d.group    = instr[GROUP_LSB +: 4];
      d.ra_index = instr[RA_LSB +: 4];
      d.rb_index = instr[RB_LSB +: 4];
      if (d.group == 4'd1) begin
         // Immediate format: opcode moves up into the rc slot, low half is the immediate.
         d.opcode       = instr[RC_LSB +: 4];
         d.imm_val      = instr[IMM_LSB +: 16];
         d.causes_stall = (d.opcode >= BNE_TWOREGS_ONESIMM);
      end else begin
         d.rc_index = instr[RC_LSB +: 4];
         d.opcode   = instr[OPC_LSB +: 4];
         case (d.group)
            4'd0:    d.causes_stall = 1'b0;
            4'd2:    d.causes_stall = (d.opcode <= CALLEQ_THREEREGS);
            4'd3:    d.causes_stall = (d.opcode <= STB_THREEREGSLDST);
            default: d.illegal      = 1'b1;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// rtl/instr_decode_stage_if.sv - fetch-side and execute-side handshakes of the decode stage
interface instr_decode_stage_if;
   import PkgInstrDecodeStage::*;

   logic                    in_valid;
   logic [31:0]             in_instr;
   logic                    in_ready;
   logic                    out_valid;
   PortOut_InstrDecodeStage out;
   logic                    out_ready;

   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out
   );

   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, out
   );

endinterface

// File: rtl/instr_decode_stage_fifo.sv
// rtl/instr_decode_stage_fifo.sv - synchronous instruction FIFO with clear
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem[rd_ptr];
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on natural overflow.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - buffered decode stage with stall tracking and illegal-instruction halt
module instr_decode_stage #(
   parameter int FIFO_DEPTH      = 4,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   instr_decode_stage_if.slave  bus,
   input  logic                 stall_clear,
   input  logic                 flush,
   output logic                 halted
);
   import PkgInstrDecodeStage::*;

   localparam int CW = $clog2(FIFO_DEPTH+1);

   logic                    fifo_full;
   logic                    fifo_empty;
   logic [CW-1:0]           fifo_count;
   logic [31:0]             fifo_head;
   logic                    push;
   logic                    load;
   PortOut_InstrDecodeStage head_dec;
   PortOut_InstrDecodeStage out_q;
   logic                    out_valid_q;
   state_t                  state;

   assign bus.in_ready  = !fifo_full && !flush;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;
   assign halted        = (state == ST_HALT);

   assign push     = bus.in_valid && bus.in_ready;
   assign head_dec = decode_instr(fifo_head);
   assign load     = !fifo_empty && (state == ST_RUN) && (!out_valid_q || bus.out_ready) && !flush;

   instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (load),
      .clear (flush),
      .wdata (bus.in_instr),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         state       <= ST_RUN;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         state       <= ST_RUN;
      end else begin
         if (load) begin
            out_q       <= head_dec;
            out_valid_q <= 1'b1;
            if (head_dec.causes_stall) begin
               state <= ST_WAIT_CLEAR;
            end else if (head_dec.illegal && HALT_ON_ILLEGAL) begin
               state <= ST_HALT;
            end
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         // Loads are blocked outside RUN, so this never races a load.
         if ((state == ST_WAIT_CLEAR) && stall_clear) begin
            state <= ST_RUN;
         end
      end
   end

   full_matches_count: assert property (@(posedge clk) disable iff (rst)
      fifo_full == (fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - scoreboard bench for instr_decode_stage
module tb_instr_decode_stage;
   import PkgInstrDecodeStage::*;

   localparam int DEPTH = 4;
   localparam bit HOI   = 1'b1;

   logic clk = 1'b0;
   logic rst;
   logic stall_clear;
   logic flush;
   logic halted;

   instr_decode_stage_if bus_if();

   instr_decode_stage #(
      .FIFO_DEPTH      (DEPTH),
      .HALT_ON_ILLEGAL (HOI)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus_if),
      .stall_clear (stall_clear),
      .flush       (flush),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   typedef enum {M_RUN, M_WAIT, M_HALT} mstate_e;

   int                      n_cmp = 0;
   int                      n_bad = 0;
   PortOut_InstrDecodeStage exp_q[$];
   mstate_e                 mstate = M_RUN;
   mstate_e                 mnext;
   bit                      accepted;
   logic ov_p = 1'b0, or_p = 1'b0, sc_p = 1'b0, fl_p = 1'b0, rst_p = 1'b1;
   logic                    newb;
   PortOut_InstrDecodeStage head;

   function automatic PortOut_InstrDecodeStage ref_decode(input logic [31:0] w);
      PortOut_InstrDecodeStage r;
      int grp;
      r          = '0;
      grp        = int'(w >> 28);
      r.group    = 4'(grp);
      r.ra_index = 4'((w >> 24) % 16);
      r.rb_index = 4'((w >> 20) % 16);
      if (grp == 1) begin
         r.opcode       = 4'((w >> 16) % 16);
         r.imm_val      = 16'(w % 65536);
         r.causes_stall = (int'(r.opcode) >= int'(BNE_TWOREGS_ONESIMM));
      end else begin
         r.rc_index = 4'((w >> 16) % 16);
         r.opcode   = 4'(w % 16);
         if (grp == 2)      r.causes_stall = (int'(r.opcode) <= int'(CALLEQ_THREEREGS));
         else if (grp == 3) r.causes_stall = (int'(r.opcode) <= int'(STB_THREEREGSLDST));
         else if (grp >= 4) r.illegal = 1'b1;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: the scoreboard learns what fetch handed over, then inputs may change.
   task automatic cycle();
      @(negedge clk);
      #1;
      accepted = 1'b0;
      if (rst || flush) begin
         exp_q.delete();
      end else if (bus_if.in_valid && bus_if.in_ready) begin
         exp_q.push_back(ref_decode(bus_if.in_instr));
         accepted = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      bus_if.in_valid = 1'b1;
      bus_if.in_instr = w;
      cycle();
      bus_if.in_valid = 1'b0;
   endtask

   // Monitor: tracks issue permission at the level of "stalled / halted / free"
   always @(negedge clk) begin
      if (rst_p) begin
         mstate = M_RUN;
      end else begin
         newb  = bus_if.out_valid && (!ov_p || or_p) && !fl_p;
         mnext = mstate;
         if (fl_p) mnext = M_RUN;
         else if (mstate == M_WAIT && sc_p) mnext = M_RUN;
         if (newb) begin
            check("load_only_when_free", (mstate == M_RUN), 1'b1);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_bundle: got 0x%0h expected none", bus_if.out);
            end else begin
               head = exp_q[0];
               if (head.causes_stall) mnext = M_WAIT;
               else if (head.illegal && HOI) mnext = M_HALT;
            end
         end
         mstate = mnext;
         check("halted", halted, (mstate == M_HALT));
      end
      if (!rst && !flush && bus_if.out_valid && bus_if.out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL consumed_extra: got 0x%0h expected none", bus_if.out);
         end else begin
            check("bundle", bus_if.out, exp_q.pop_front());
         end
      end
      ov_p  = bus_if.out_valid;
      or_p  = bus_if.out_ready;
      sc_p  = stall_clear;
      fl_p  = flush;
      rst_p = rst;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      logic [31:0] stall_w;
      stall_w = {4'h1, 4'h1, 4'h2, BNE_TWOREGS_ONESIMM, 16'hBEEF};

      rst = 1'b1; flush = 1'b0; stall_clear = 1'b0;
      bus_if.in_valid = 1'b0; bus_if.in_instr = '0; bus_if.out_ready = 1'b0;
      repeat (3) cycle();
      rst = 1'b0;
      check("rst_out_valid", bus_if.out_valid, 1'b0);
      check("rst_out", bus_if.out, '0);
      check("rst_halted", halted, 1'b0);
      check("rst_in_ready", bus_if.in_ready, 1'b1);

      // Two-edge latency with no bypass
      push(32'h0123_0004);
      check("latency_e0", bus_if.out_valid, 1'b0);
      cycle();
      check("latency_e1", bus_if.out_valid, 1'b1);
      bus_if.out_ready = 1'b1;
      cycle();

      // Streaming group 0 with execute always ready
      for (int i = 0; i < 8; i++) begin
         bus_if.in_valid = 1'b1;
         bus_if.in_instr = {4'h0, 28'($urandom)};
         cycle();
         check("stream_accept", accepted, 1'b1);
      end
      bus_if.in_valid = 1'b0;
      repeat (3) cycle();

      // Backpressure: DEPTH queued plus one in the output register
      bus_if.out_ready = 1'b0;
      idx = 0;
      for (int i = 0; i < 8; i++) begin
         bus_if.in_valid = 1'b1;
         bus_if.in_instr = {4'h0, 4'(idx), 8'h00, 16'(idx * 3 + 1)};
         cycle();
         if (accepted) idx++;
      end
      bus_if.in_valid = 1'b0;
      check("bp_accepted", idx, DEPTH + 1);
      check("bp_in_ready", bus_if.in_ready, 1'b0);
      bus_if.out_ready = 1'b1;
      repeat (8) cycle();
      check("bp_drained", exp_q.size(), 0);

      // Stall hold until stall_clear
      push(stall_w);
      push(32'h0456_0007);
      push(32'h0789_000A);
      repeat (4) cycle();
      check("stall_held", bus_if.out_valid, 1'b0);
      stall_clear = 1'b1;
      cycle();
      stall_clear = 1'b0;
      check("no_load_on_clear", bus_if.out_valid, 1'b0);
      cycle();
      check("load_after_clear", bus_if.out_valid, 1'b1);
      repeat (3) cycle();

      // Illegal group halts until flush
      bus_if.out_ready = 1'b0;
      push(32'h5000_0000);
      push(32'h0123_0004);
      repeat (2) cycle();
      check("illegal_halted", halted, 1'b1);
      check("illegal_valid", bus_if.out_valid, 1'b1);
      bus_if.out_ready = 1'b1;
      repeat (4) cycle();
      check("halt_holds_issue", bus_if.out_valid, 1'b0);
      check("halt_persists", halted, 1'b1);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      check("flush_unhalt", halted, 1'b0);
      check("flush_out_valid", bus_if.out_valid, 1'b0);
      repeat (2) cycle();
      check("flush_fifo_empty", bus_if.out_valid, 1'b0);

      // Flush in WAIT_CLEAR with coincident stall_clear and in_valid
      push(stall_w);
      push(32'h0123_0004);
      repeat (3) cycle();
      flush = 1'b1; stall_clear = 1'b1;
      bus_if.in_valid = 1'b1; bus_if.in_instr = 32'h0AAA_0001;
      cycle();
      check("flush_drops_input", accepted, 1'b0);
      flush = 1'b0; stall_clear = 1'b0; bus_if.in_valid = 1'b0;
      check("wflush_out_valid", bus_if.out_valid, 1'b0);
      repeat (2) cycle();
      check("wflush_empty", bus_if.out_valid, 1'b0);
      push(32'h0123_0004);
      cycle();
      check("wflush_run", bus_if.out_valid, 1'b1);
      repeat (2) cycle();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic [3:0] g;
         g = (($urandom % 16) == 0) ? 4'(4 + $urandom % 12) : 4'($urandom % 4);
         bus_if.in_valid  = (($urandom % 4) != 0);
         bus_if.in_instr  = {g, 28'($urandom)};
         bus_if.out_ready = (($urandom % 4) != 0);
         stall_clear      = (($urandom % 6) == 0);
         flush            = (($urandom % 40) == 0);
         cycle();
      end

      bus_if.in_valid = 1'b0; flush = 1'b0;
      bus_if.out_ready = 1'b1; stall_clear = 1'b1;
      repeat (40) cycle();
      stall_clear = 1'b0;
      if (mstate != M_HALT) check("final_drain", exp_q.size(), 0);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      repeat (2) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
